// File: rtl/char_recog_pkg.sv
`default_nettype none
// ============================================================================
// Module   : char_recog_pkg
// Purpose  : Shared types and constants for the character-recognition
//            scheduler: FSM state encoding, digit width, no-match code and
//            box-count width.
// Ports    : (package, none)
// Revision : 1.0 - initial release
// ============================================================================
package char_recog_pkg;

  // Scheduler FSM states
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_FRAME = 3'd1,
    ST_SCAN       = 3'd2,
    ST_SETTLE     = 3'd3,
    ST_CAPTURE    = 3'd4,
    ST_DONE       = 3'd5
  } state_t;

  localparam int                 DIGIT_W  = 4;     // packed digit width
  localparam logic [DIGIT_W-1:0] NO_MATCH = 4'd8;  // recogniser "no digit" code
  localparam int                 CNT_W    = 4;     // box_count / index width

endpackage
`default_nettype wire

// File: rtl/char_result_bank.sv
`default_nettype none
// ============================================================================
// Module   : char_result_bank
// Purpose  : Per-slot storage of recognised digits and miss flags, packed
//            for the downstream consumer.
// Ports    : clk_i / rst_i  - clock, asynchronous active-high reset
//            clr_i          - clear all slots (wins over write)
//            we_i, idx_i    - write enable and target slot
//            digit_i/miss_i - data written into the slot
//            digits_o       - slot i at [i*4 +: 4]
//            miss_o         - bit i = slot i had no match
// Revision : 1.0 - initial release
// ============================================================================
module char_result_bank
  import char_recog_pkg::*;
#(
  parameter int MAX_CHARS = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clr_i,
  input  logic                           we_i,
  input  logic [CNT_W-1:0]               idx_i,
  input  logic [DIGIT_W-1:0]             digit_i,
  input  logic                           miss_i,
  output logic [MAX_CHARS*DIGIT_W-1:0]   digits_o,
  output logic [MAX_CHARS-1:0]           miss_o
);

  for (genvar i = 0; i < MAX_CHARS; i++) begin : g_slot
    logic [DIGIT_W-1:0] digit_q;
    logic               miss_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        digit_q <= '0;
        miss_q  <= 1'b0;
      end else if (clr_i) begin
        digit_q <= '0;
        miss_q  <= 1'b0;
      end else if (we_i && (idx_i == CNT_W'(i))) begin
        digit_q <= digit_i;
        miss_q  <= miss_i;
      end
    end

    assign digits_o[i*DIGIT_W +: DIGIT_W] = digit_q;
    assign miss_o[i]                      = miss_q;
  end

endmodule
`default_nettype wire

// File: rtl/char_recog_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : char_recog_scheduler
// Purpose  : Time-shares one digit recogniser across up to MAX_CHARS boxes,
//            one full video frame per box, then presents the packed digit
//            string on a valid/ready handshake.
// Ports    : pixelclk, reset       - clock, asynchronous active-high reset
//            box_load/count/left/right - box list from segmentation
//            frame_start/frame_end - frame pulses
//            char_result           - recogniser output (8 = no match)
//            roi_left/roi_right    - column window for the recogniser
//            cnt_clear             - accumulator clear pulse
//            busy                  - job in progress
//            result_valid/ready, result_digits/miss/count - packed result
// Revision : 1.0 - initial release
// ============================================================================
module char_recog_scheduler
  import char_recog_pkg::*;
#(
  parameter int MAX_CHARS  = 4,
  parameter int COORD_W    = 12,
  parameter int SETTLE_CYC = 2
) (
  input  logic                           pixelclk,
  input  logic                           reset,
  input  logic                           box_load,
  input  logic [CNT_W-1:0]               box_count,
  input  logic [MAX_CHARS*COORD_W-1:0]   box_left,
  input  logic [MAX_CHARS*COORD_W-1:0]   box_right,
  input  logic                           frame_start,
  input  logic                           frame_end,
  input  logic [7:0]                     char_result,
  output logic [COORD_W-1:0]             roi_left,
  output logic [COORD_W-1:0]             roi_right,
  output logic                           cnt_clear,
  output logic                           busy,
  output logic                           result_valid,
  input  logic                           result_ready,
  output logic [MAX_CHARS*DIGIT_W-1:0]   result_digits,
  output logic [MAX_CHARS-1:0]           result_miss,
  output logic [CNT_W-1:0]               result_count
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               idx_q, idx_d;
  logic [CNT_W-1:0]               count_q, count_d;
  logic [MAX_CHARS*COORD_W-1:0]   left_q, left_d;
  logic [MAX_CHARS*COORD_W-1:0]   right_q, right_d;
  logic [COORD_W-1:0]             roi_left_q, roi_left_d;
  logic [COORD_W-1:0]             roi_right_q, roi_right_d;
  logic                           cnt_clear_q, cnt_clear_d;
  logic [SET_W-1:0]               settle_q, settle_d;

  logic                           bank_we, bank_clr;
  logic [CNT_W-1:0]               idx_next;
  logic                           cap_miss;
  logic [DIGIT_W-1:0]             cap_digit;

  assign idx_next  = idx_q + 1'b1;
  // Anything 8 or above is a no-match; it is normalised to the 8 code.
  assign cap_miss  = (char_result >= 8'd8);
  assign cap_digit = cap_miss ? NO_MATCH : char_result[DIGIT_W-1:0];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    count_d     = count_q;
    left_d      = left_q;
    right_d     = right_q;
    roi_left_d  = roi_left_q;
    roi_right_d = roi_right_q;
    settle_d    = settle_q;
    cnt_clear_d = 1'b0;
    bank_we     = 1'b0;
    bank_clr    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (box_load && (box_count != '0)) begin
          left_d      = box_left;
          right_d     = box_right;
          count_d     = (box_count > CNT_W'(MAX_CHARS)) ? CNT_W'(MAX_CHARS) : box_count;
          idx_d       = '0;
          // Window comes straight from the inputs so it is valid next cycle.
          roi_left_d  = box_left[COORD_W-1:0];
          roi_right_d = box_right[COORD_W-1:0];
          state_d     = ST_WAIT_FRAME;
        end
      end
      ST_WAIT_FRAME: begin
        if (frame_start) begin
          cnt_clear_d = 1'b1;
          state_d     = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (frame_end) begin
          settle_d = '0;
          state_d  = ST_SETTLE;
        end else if (frame_start) begin
          // Missed frame end: restart accumulation on this same box.
          cnt_clear_d = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (settle_q == SET_W'(SETTLE_CYC - 1)) begin
          state_d = ST_CAPTURE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_CAPTURE: begin
        bank_we = 1'b1;
        idx_d   = idx_next;
        if (idx_next == count_q) begin
          state_d = ST_DONE;
        end else begin
          for (int i = 0; i < MAX_CHARS; i++) begin
            if (idx_next == CNT_W'(i)) begin
              roi_left_d  = left_q[i*COORD_W +: COORD_W];
              roi_right_d = right_q[i*COORD_W +: COORD_W];
            end
          end
          state_d = ST_WAIT_FRAME;
        end
      end
      ST_DONE: begin
        if (result_ready) begin
          bank_clr = 1'b1;
          count_d  = '0;
          idx_d    = '0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      count_q     <= '0;
      left_q      <= '0;
      right_q     <= '0;
      roi_left_q  <= '0;
      roi_right_q <= '0;
      cnt_clear_q <= 1'b0;
      settle_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      left_q      <= left_d;
      right_q     <= right_d;
      roi_left_q  <= roi_left_d;
      roi_right_q <= roi_right_d;
      cnt_clear_q <= cnt_clear_d;
      settle_q    <= settle_d;
    end
  end

  char_result_bank #(
    .MAX_CHARS (MAX_CHARS)
  ) u_bank (
    .clk_i    (pixelclk),
    .rst_i    (reset),
    .clr_i    (bank_clr),
    .we_i     (bank_we),
    .idx_i    (idx_q),
    .digit_i  (cap_digit),
    .miss_i   (cap_miss),
    .digits_o (result_digits),
    .miss_o   (result_miss)
  );

  assign roi_left     = roi_left_q;
  assign roi_right    = roi_right_q;
  assign cnt_clear    = cnt_clear_q;
  assign busy         = (state_q != ST_IDLE);
  assign result_valid = (state_q == ST_DONE);
  assign result_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_char_recog_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_char_recog_scheduler
// Purpose  : Self-checking bench for char_recog_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_char_recog_scheduler;

  localparam int MC = 4;
  localparam int CW = 12;
  localparam int SC = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              box_load = 1'b0;
  logic [3:0]        box_count = '0;
  logic [MC*CW-1:0]  box_left = '0;
  logic [MC*CW-1:0]  box_right = '0;
  logic              frame_start = 1'b0;
  logic              frame_end = 1'b0;
  logic [7:0]        char_result = '0;
  logic              result_ready = 1'b0;
  logic [CW-1:0]     roi_left, roi_right;
  logic              cnt_clear, busy, result_valid;
  logic [MC*4-1:0]   result_digits;
  logic [MC-1:0]     result_miss;
  logic [3:0]        result_count;

  always #5 clk = ~clk;

  char_recog_scheduler #(
    .MAX_CHARS  (MC),
    .COORD_W    (CW),
    .SETTLE_CYC (SC)
  ) dut (
    .pixelclk      (clk),
    .reset         (rst),
    .box_load      (box_load),
    .box_count     (box_count),
    .box_left      (box_left),
    .box_right     (box_right),
    .frame_start   (frame_start),
    .frame_end     (frame_end),
    .char_result   (char_result),
    .roi_left      (roi_left),
    .roi_right     (roi_right),
    .cnt_clear     (cnt_clear),
    .busy          (busy),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .result_digits (result_digits),
    .result_miss   (result_miss),
    .result_count  (result_count)
  );

  typedef struct packed {
    logic [3:0]           cnt;
    logic [3:0][CW-1:0]   l;
    logic [3:0][CW-1:0]   r;
    logic [3:0][7:0]      ch;
    logic [15:0]          ed;
    logic [3:0]           em;
    logic [3:0]           ec;
  } vec_t;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  m;
    logic [3:0]  c;
  } res_t;

  vec_t vecs[4];
  res_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   clr_pulses = 0;

  always @(posedge clk) if (cnt_clear === 1'b1) clr_pulses++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int nslots(input vec_t v);
    return (v.cnt > 4'd4) ? 4 : int'(v.cnt);
  endfunction

  task automatic load_job(input vec_t v);
    res_t e;
    box_count = v.cnt;
    box_left  = v.l;
    box_right = v.r;
    box_load  = 1'b1;
    tick();
    box_load  = 1'b0;
    chk("load_busy", busy, 1);
    chk("load_roi_left", roi_left, v.l[0]);
    chk("load_roi_right", roi_right, v.r[0]);
    e.d = v.ed; e.m = v.em; e.c = v.ec;
    sb.push_back(e);
  endtask

  task automatic do_frame(input vec_t v, input int s, input bit last);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("clear_pulse", cnt_clear, 1);
    tick();
    chk("clear_one_cycle", cnt_clear, 0);
    repeat (3) tick();
    char_result = v.ch[s];
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    repeat (SC) tick();
    if (last) chk("valid_not_early", result_valid, 0);
    tick();
    if (last) begin
      chk("valid_latency", result_valid, 1);
    end else begin
      chk("roi_step_left", roi_left, v.l[s+1]);
      chk("roi_step_right", roi_right, v.r[s+1]);
    end
  endtask

  task automatic run_frames(input vec_t v);
    int c0, n;
    n  = nslots(v);
    c0 = clr_pulses;
    for (int s = 0; s < n; s++) do_frame(v, s, s == n - 1);
    chk("clear_count", clr_pulses - c0, n);
  endtask

  task automatic get_result;
    res_t e;
    int k;
    k = 0;
    while (result_valid !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    if (result_valid !== 1'b1) begin
      chk("result_timeout", 0, 1);
    end else if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("result_digits", result_digits, e.d);
      chk("result_miss", result_miss, e.m);
      chk("result_count", result_count, e.c);
    end
  endtask

  task automatic handshake;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("hs_valid", result_valid, 0);
    chk("hs_busy", busy, 0);
    chk("hs_digits", result_digits, 0);
    chk("hs_miss", result_miss, 0);
    chk("hs_count", result_count, 0);
  endtask

  initial begin
    vec_t v;
    // 3 boxes, clean digits
    vecs[0].cnt = 4'd3;
    vecs[0].l   = {12'd0, 12'd90, 12'd50, 12'd10};
    vecs[0].r   = {12'd0, 12'd120, 12'd80, 12'd40};
    vecs[0].ch  = {8'd0, 8'd0, 8'd7, 8'd3};
    vecs[0].ed  = 16'h0073; vecs[0].em = 4'b0000; vecs[0].ec = 4'd3;
    // slot 1 no match
    vecs[1].cnt = 4'd3;
    vecs[1].l   = {12'd0, 12'd300, 12'd200, 12'd100};
    vecs[1].r   = {12'd0, 12'd350, 12'd250, 12'd150};
    vecs[1].ch  = {8'd0, 8'd5, 8'd8, 8'd3};
    vecs[1].ed  = 16'h0583; vecs[1].em = 4'b0010; vecs[1].ec = 4'd3;
    // count 6 clamped to 4; result 9 stored as 8 with miss
    vecs[2].cnt = 4'd6;
    vecs[2].l   = {12'd700, 12'd500, 12'd300, 12'd100};
    vecs[2].r   = {12'd800, 12'd600, 12'd400, 12'd200};
    vecs[2].ch  = {8'd4, 8'd9, 8'd2, 8'd1};
    vecs[2].ed  = 16'h4821; vecs[2].em = 4'b0100; vecs[2].ec = 4'd4;
    // single box at coordinate extremes
    vecs[3].cnt = 4'd1;
    vecs[3].l   = {12'd0, 12'd0, 12'd0, 12'd17};
    vecs[3].r   = {12'd0, 12'd0, 12'd0, 12'd4095};
    vecs[3].ch  = {8'd0, 8'd0, 8'd0, 8'd7};
    vecs[3].ed  = 16'h0007; vecs[3].em = 4'b0000; vecs[3].ec = 4'd1;

    // Reset values
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_roi_left", roi_left, 0);
    chk("rst_roi_right", roi_right, 0);
    chk("rst_clear", cnt_clear, 0);
    chk("rst_digits", result_digits, 0);
    chk("rst_count", result_count, 0);
    rst = 1'b0;
    tick();

    // box_count=0 ignored
    box_count = 4'd0;
    box_load  = 1'b1;
    tick();
    box_load  = 1'b0;
    chk("zero_load_busy", busy, 0);
    tick();
    chk("zero_load_busy2", busy, 0);

    // Table-driven jobs
    for (int i = 0; i < 4; i++) begin
      load_job(vecs[i]);
      run_frames(vecs[i]);
      get_result();
      handshake();
    end

    // frame_end in WAIT_FRAME ignored; double frame_start restarts the scan
    v = '0;
    v.cnt = 4'd1; v.l = {36'd0, 12'd200}; v.r = {36'd0, 12'd300};
    v.ed = 16'h0006; v.em = 4'b0; v.ec = 4'd1;
    load_job(v);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    repeat (5) tick();
    chk("wait_ignores_end", result_valid, 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("dbl_clear1", cnt_clear, 1);
    char_result = 8'd2;
    repeat (3) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("dbl_clear2", cnt_clear, 1);
    chk("dbl_roi_hold", roi_left, 200);
    repeat (10) tick();
    chk("dbl_no_result", result_valid, 0);
    char_result = 8'd6;
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    get_result();
    handshake();

    // DONE holds under back-pressure; box_load ignored there
    load_job(vecs[1]);
    run_frames(vecs[1]);
    get_result();
    for (int j = 0; j < 20; j++) begin
      if (j == 5) begin
        box_count = vecs[0].cnt;
        box_left  = vecs[0].l;
        box_right = vecs[0].r;
        box_load  = 1'b1;
      end else begin
        box_load  = 1'b0;
      end
      tick();
      if (j == 0 || j == 6 || j == 19) begin
        chk("hold_valid", result_valid, 1);
        chk("hold_digits", result_digits, 16'h0583);
        chk("hold_miss", result_miss, 4'b0010);
        chk("hold_roi", roi_left, 300);
      end
    end
    box_load = 1'b0;
    handshake();
    load_job(vecs[3]);
    run_frames(vecs[3]);
    get_result();
    handshake();

    // Reset mid-SCAN on slot 1
    load_job(vecs[0]);
    do_frame(vecs[0], 0, 1'b0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    rst = 1'b1;
    #2;
    chk("abort_busy", busy, 0);
    chk("abort_roi_left", roi_left, 0);
    chk("abort_roi_right", roi_right, 0);
    chk("abort_clear", cnt_clear, 0);
    chk("abort_digits", result_digits, 0);
    chk("abort_count", result_count, 0);
    void'(sb.pop_back());
    tick();
    rst = 1'b0;
    tick();
    load_job(vecs[1]);
    run_frames(vecs[1]);
    get_result();
    handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
